// File: rtl/wb_regfile_pkg.sv
// Shared core constants for the write-back register file.
package wb_regfile_pkg;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 1 << REG_IDX_W;
endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: x0 returns 0, same-cycle write-back bypass, zero output in reset.
module regfile_read_port #(
    parameter int W = 32,
    parameter int R = 5
) (
    input  logic                         rst,
    input  logic [R-1:0]                 rs,
    input  logic [(1<<R)-1:0][W-1:0]     regs,
    input  logic                         wr_hit,
    input  logic [R-1:0]                 wr_rd,
    input  logic [W-1:0]                 wr_data,
    output logic [W-1:0]                 rd_data
);
    // wr_hit already excludes rd=0, and regs[0] is tied to zero, so x0 needs no special case.
    always_comb begin
        rd_data = regs[rs];
        if (rst) begin
            rd_data = '0;
        end else if (wr_hit && (rs == wr_rd)) begin
            rd_data = wr_data;
        end
    end
endmodule

// File: rtl/wb_regfile.sv
// Flop-based integer register file with two combinational read ports,
// write-first bypass and a committed-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int W = XLEN,
    parameter int R = REG_IDX_W
) (
    input  logic         clk,
    input  logic         a_reset,
    input  logic [W-1:0] in_result,
    input  logic [R-1:0] in_rd,
    input  logic         in_useRd,
    input  logic [R-1:0] in_rs1,
    input  logic [R-1:0] in_rs2,
    output logic [W-1:0] out_rs1_data,
    output logic [W-1:0] out_rs2_data,
    output logic [15:0]  out_wr_count
);
    localparam int N = 1 << R;

    logic [W-1:0]          regs_q [1:N-1];
    logic [W-1:0]          regs_d [1:N-1];
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic                  wr_hit;
    logic [N-1:0][W-1:0]   regs_view;

    assign wr_hit = in_useRd && (in_rd != '0);

    always_comb begin
        regs_d   = regs_q;
        wr_cnt_d = wr_cnt_q;
        if (wr_hit) begin
            regs_d[in_rd] = in_result;
            wr_cnt_d      = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge a_reset) begin
        if (a_reset) begin
            for (int i = 1; i < N; i++) regs_q[i] <= '0;
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Slot 0 of the read view is hard-wired zero: x0 has no storage.
    always_comb begin
        regs_view = '0;
        for (int i = 1; i < N; i++) regs_view[i] = regs_q[i];
    end

    regfile_read_port #(.W(W), .R(R)) u_rp1 (
        .rst     (a_reset),
        .rs      (in_rs1),
        .regs    (regs_view),
        .wr_hit  (wr_hit),
        .wr_rd   (in_rd),
        .wr_data (in_result),
        .rd_data (out_rs1_data)
    );

    regfile_read_port #(.W(W), .R(R)) u_rp2 (
        .rst     (a_reset),
        .rs      (in_rs2),
        .regs    (regs_view),
        .wr_hit  (wr_hit),
        .wr_rd   (in_rd),
        .wr_data (in_result),
        .rd_data (out_rs2_data)
    );

    assign out_wr_count = wr_cnt_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, x0, bypass, counter wrap, mid-stream reset.
module tb_wb_regfile;
    logic        clk = 1'b0;
    logic        a_reset;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_useRd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [15:0] out_wr_count;

    int checks = 0;
    int errors = 0;

    wb_regfile dut (
        .clk          (clk),
        .a_reset      (a_reset),
        .in_result    (in_result),
        .in_rd        (in_rd),
        .in_useRd     (in_useRd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_wr_count (out_wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, checks happen before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] data);
        in_useRd  = 1'b1;
        in_rd     = rd;
        in_result = data;
        tick();
    endtask

    task automatic idle();
        in_useRd  = 1'b0;
        in_rd     = 5'd0;
        in_result = 32'h0;
    endtask

    initial begin
        a_reset   = 1'b1;
        in_useRd  = 1'b1;
        in_rd     = 5'd5;
        in_result = 32'hFEEDFACE;
        in_rs1    = 5'd5;
        in_rs2    = 5'd0;
        #2;
        // Bypass suppressed and storage held clear while reset is high.
        chk("rst_bypass_suppressed", out_rs1_data, 32'h0);
        tick();
        tick();
        chk("rst_no_commit_count", {16'h0, out_wr_count}, 32'h0);
        idle();
        for (int i = 0; i < 32; i++) begin
            in_rs1 = 5'(i);
            in_rs2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rs1_x%0d", i), out_rs1_data, 32'h0);
            chk($sformatf("rst_rs2_x%0d", 31 - i), out_rs2_data, 32'h0);
        end

        // Write presented as reset releases commits on the next rising edge.
        @(negedge clk);
        a_reset   = 1'b0;
        in_useRd  = 1'b1;
        in_rd     = 5'd5;
        in_result = 32'hDEADBEEF;
        tick();
        idle();
        in_rs1 = 5'd5;
        in_rs2 = 5'd5;
        #1;
        chk("x5_rs1", out_rs1_data, 32'hDEADBEEF);
        chk("x5_rs2", out_rs2_data, 32'hDEADBEEF);
        chk("x5_count", {16'h0, out_wr_count}, 32'd1);

        // Write to x0 is discarded.
        in_useRd  = 1'b1;
        in_rd     = 5'd0;
        in_result = 32'h12345678;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        #1;
        chk("x0_during_write", out_rs1_data, 32'h0);
        tick();
        idle();
        #1;
        chk("x0_after_write", out_rs1_data, 32'h0);
        chk("x0_count", {16'h0, out_wr_count}, 32'd1);

        // Bypass on one port, stored value on the other.
        wr(5'd8, 32'h11);
        in_useRd  = 1'b1;
        in_rd     = 5'd7;
        in_result = 32'hA5A5A5A5;
        in_rs1    = 5'd7;
        in_rs2    = 5'd8;
        #1;
        chk("byp_rs1", out_rs1_data, 32'hA5A5A5A5);
        chk("byp_rs2_stored", out_rs2_data, 32'h11);
        tick();
        // Bypass on both ports at once.
        in_rd     = 5'd9;
        in_result = 32'h99;
        in_rs1    = 5'd9;
        in_rs2    = 5'd9;
        #1;
        chk("byp_both_rs1", out_rs1_data, 32'h99);
        chk("byp_both_rs2", out_rs2_data, 32'h99);
        tick();
        idle();
        #1;
        chk("byp_count", {16'h0, out_wr_count}, 32'd4);

        // Back-to-back writes, then idle cycles with garbage on rd/result.
        wr(5'd3, 32'h1);
        wr(5'd3, 32'h2);
        wr(5'd3, 32'h3);
        in_useRd  = 1'b0;
        in_rd     = 5'd3;
        in_result = 32'hFFFFFFFF;
        tick();
        tick();
        idle();
        in_rs1 = 5'd3;
        in_rs2 = 5'd7;
        #1;
        chk("b2b_x3", out_rs1_data, 32'h3);
        chk("b2b_x7_kept", out_rs2_data, 32'hA5A5A5A5);
        chk("b2b_count", {16'h0, out_wr_count}, 32'd7);

        // Fill the counter to 0xFFFF, then wrap.
        for (int i = 0; i < 65528; i++) wr(5'd10, 32'(i));
        idle();
        in_rs1 = 5'd10;
        #1;
        chk("cnt_ffff", {16'h0, out_wr_count}, 32'h0000FFFF);
        chk("x10_last", out_rs1_data, 32'd65527);
        wr(5'd10, 32'hC0DE);
        idle();
        #1;
        chk("cnt_wrap", {16'h0, out_wr_count}, 32'h0);
        chk("x10_wrap_write", out_rs1_data, 32'hC0DE);

        // Reset mid-write: storage clears at once, the pending write is dropped.
        in_useRd  = 1'b1;
        in_rd     = 5'd5;
        in_result = 32'hCAFEF00D;
        in_rs1    = 5'd5;
        in_rs2    = 5'd10;
        @(negedge clk);
        a_reset = 1'b1;
        #1;
        chk("midrst_x5", out_rs1_data, 32'h0);
        chk("midrst_x10", out_rs2_data, 32'h0);
        tick();
        @(negedge clk);
        idle();
        a_reset = 1'b0;
        #1;
        chk("postrst_x5", out_rs1_data, 32'h0);
        chk("postrst_x10", out_rs2_data, 32'h0);
        chk("postrst_count", {16'h0, out_wr_count}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter W, default 32, data width of each architectural register.
REQ-002 Parameter R, default 5, register index width; register count is 2^R.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 a_reset  input  1  asynchronous, active-high reset.
REQ-005 in_result  input  W  write-back data from the mem2wb pipeline register.
REQ-006 in_rd  input  R  destination register index from the mem2wb pipeline register.
REQ-007 in_useRd  input  1  write enable from the mem2wb pipeline register; 1 means write in_result to in_rd.
REQ-008 in_rs1  input  R  decode-stage read index, port 1.
REQ-009 in_rs2  input  R  decode-stage read index, port 2.
REQ-010 out_rs1_data  output  W  read data, port 1, combinational.
REQ-011 out_rs2_data  output  W  read data, port 2, combinational.
REQ-012 out_wr_count  output  16  count of committed non-x0 writes since reset, registered.

Function
REQ-013 The block SHALL hold 2^R-1 writable registers x1..x(2^R-1); x0 SHALL have no storage.
REQ-014 On each rising clk with in_useRd=1 and in_rd!=0, the block SHALL store in_result into register in_rd.
REQ-015 A write with in_rd=0 SHALL be discarded: no storage change, no out_wr_count increment.
REQ-016 A write with in_useRd=0 SHALL change no state, regardless of in_rd and in_result.
REQ-017 Reads SHALL be combinational, with zero-cycle latency from in_rs1/in_rs2 to the data outputs.
REQ-018 Index 0 on either read port SHALL return 0, even during a write to rd=0.
REQ-019 Write-first bypass: when in_useRd=1, in_rd!=0 and in_rsN==in_rd, out_rsN_data SHALL equal in_result in the same cycle.
REQ-020 Bypass SHALL apply independently to both ports; both ports reading in_rd SHALL both return in_result.
REQ-021 Without a bypass hit, out_rsN_data SHALL equal the stored value of register in_rsN.
REQ-022 out_wr_count SHALL increment by 1 on each clock that performs a write per REQ-014.
REQ-023 out_wr_count SHALL wrap from 0xFFFF to 0x0000 with no flag.
REQ-024 Back-to-back writes to the same rd SHALL leave the last written value; no write is lost or reordered.

Reset
REQ-025 While a_reset=1, all registers x1..x(2^R-1) SHALL asynchronously clear to 0 and out_wr_count SHALL be 0.
REQ-026 During reset, read outputs SHALL return 0 for every index, and the bypass path SHALL be suppressed.
REQ-027 A write presented in the cycle a_reset deasserts SHALL commit on the first rising edge after deassertion.
REQ-028 Reset asserted mid-stream SHALL discard any write on that edge; no partial update.

Structure
REQ-029 XLEN (32), REG_IDX_W (5) and NUM_REGS (32) SHALL live in the shared core package; parameter defaults SHALL come from it.
REQ-030 Per-port read/bypass muxing SHALL be one sub-module, regfile_read_port, instantiated twice.
REQ-031 Storage SHALL be flops (no SRAM macro); bypass logic SHALL be combinational, outside the clocked process.

Verification
REQ-032 Reset, then read all 32 indices on both ports -> every read returns 0x00000000 and out_wr_count=0.
REQ-033 Write x5=0xDEADBEEF, then next cycle in_rs1=5, in_rs2=5 -> both ports return 0xDEADBEEF; out_wr_count=1.
REQ-034 in_useRd=1, in_rd=0, in_result=0x12345678, in_rs1=0 -> out_rs1_data=0; a later read of x0 is 0; out_wr_count unchanged.
REQ-035 Same cycle: in_useRd=1, in_rd=7, in_result=0xA5A5A5A5, in_rs1=7, in_rs2=8 (x8=0x11) -> port1=0xA5A5A5A5 (bypass), port2=0x00000011.
REQ-036 Writes to x3 of 0x1, 0x2, 0x3 on consecutive cycles, then read x3 -> 0x3; out_wr_count advanced by 3; in_useRd=0 cycles change nothing.
REQ-037 Preload out_wr_count to 0xFFFF with 65535 writes, one more write -> out_wr_count=0x0000; assert a_reset mid-write -> x-register cleared, write dropped.
